// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, op decode helpers.
package muldiv_hilo_unit_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULTU = 3'b000;
  localparam logic [OP_W-1:0] OP_MULT  = 3'b001;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV   = 3'b011;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Codes 110/111 are NOPs even when start is high.
  function automatic logic op_is_reserved(input logic [OP_W-1:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return ~op[2];
  endfunction

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return ~op[2] & op[1];
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return ~op[2] & op[0];
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per step.
// Result ports show the post-step value so the caller can commit on the final step edge.
module muldiv_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_c_o,
  output logic [WIDTH-1:0] res_hi_c_o,
  output logic [WIDTH-1:0] res_lo_c_o
);

  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   sum_c, rem_sh_c, diff_c;

  assign sum_c    = {1'b0, acc_hi_q} + {1'b0, m_q};
  assign rem_sh_c = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign diff_c   = rem_sh_c - {1'b0, m_q};

  // acc_lo holds the multiplier (mul) or the dividend shifting into quotient bits (div).
  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    if (load_i) begin
      acc_hi_d = '0;
      acc_lo_d = is_div_i ? a_i : b_i;
      m_d      = is_div_i ? b_i : a_i;
      div_d    = is_div_i;
      cnt_d    = CNT_W'(WIDTH);
    end else if (step_i) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (div_q) begin
        if (!diff_c[WIDTH]) begin
          acc_hi_d = diff_c[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = rem_sh_c[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
      end else if (acc_lo_q[0]) begin
        {acc_hi_d, acc_lo_d} = {sum_c, acc_lo_q[WIDTH-1:1]};
      end else begin
        {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
    end
  end

  assign last_c_o   = (cnt_q == CNT_W'(1));
  assign res_hi_c_o = acc_hi_d;
  assign res_lo_c_o = acc_lo_d;

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle MULT/DIV engine with architectural HI/LO: FSM, sign fix-up and HI/LO registers.
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic               sgn_q, isdiv_q, negq_q, negr_q;
  logic               accept_c, sgn_c, step_c, last_c;
  logic [WIDTH-1:0]   a_mag_c, b_mag_c, res_hi_c, res_lo_c;
  logic [2*WIDTH-1:0] prod_c;

  assign accept_c = (state_q == ST_IDLE) && start && op_is_arith(op);
  assign sgn_c    = op_is_signed(op);
  assign a_mag_c  = (sgn_c && a[WIDTH-1]) ? -a : a;
  assign b_mag_c  = (sgn_c && b[WIDTH-1]) ? -b : b;
  assign step_c   = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign prod_c   = {res_hi_c, res_lo_c};

  muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept_c),
    .step_i     (step_c),
    .is_div_i   (op_is_div(op)),
    .a_i        (a_mag_c),
    .b_i        (b_mag_c),
    .last_c_o   (last_c),
    .res_hi_c_o (res_hi_c),
    .res_lo_c_o (res_lo_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !op_is_reserved(op) && op_is_arith(op)) begin
          if (!op_is_div(op))  state_d = ST_MUL;
          else if (b != '0)    state_d = ST_DIV;
          else                 state_d = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (last_c) state_d = sgn_q ? ST_FIX : ST_DONE;
      ST_FIX:         state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // HI/LO only move on MTxx, divide-by-zero, or the edge that enters DONE.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    dbz_d  = 1'b0;
    busy_d = state_d inside {ST_MUL, ST_DIV, ST_FIX};
    done_d = (state_d == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (start && !op_is_reserved(op)) begin
          if (op == OP_MTHI)            hi_d = a;
          else if (op == OP_MTLO)       lo_d = a;
          else if (state_d == ST_DONE) begin
            hi_d  = a;
            lo_d  = '1;
            dbz_d = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (state_d == ST_DONE) begin
          hi_d = res_hi_c;
          lo_d = res_lo_c;
        end
      end
      ST_FIX: begin
        if (isdiv_q) begin
          hi_d = negr_q ? -res_hi_c : res_hi_c;
          lo_d = negq_q ? -res_lo_c : res_lo_c;
        end else begin
          {hi_d, lo_d} = negq_q ? -prod_c : prod_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dbz_q  <= dbz_d;
    end
  end

  // Sign of quotient/product and of remainder, captured with the operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_q   <= 1'b0;
      isdiv_q <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else if (accept_c) begin
      sgn_q   <= sgn_c;
      isdiv_q <= op_is_div(op);
      negq_q  <= sgn_c & (a[WIDTH-1] ^ b[WIDTH-1]);
      negr_q  <= sgn_c & a[WIDTH-1];
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed scoreboard bench for muldiv_hilo_unit: results from native-arithmetic reference model.
module tb_muldiv_hilo_unit;
  import muldiv_hilo_unit_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           busy_cyc;
  } exp_t;

  exp_t sb_q[$];

  muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [2:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.tag = tag;
    e.dbz = 1'b0;
    e.hi  = '0;
    e.lo  = '0;
    e.lat = 0;
    case (o)
      3'b000: begin
        p = {32'b0, x} * {32'b0, y};
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33;
      end
      3'b001: begin
        p = 64'(sx * sy);
        e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 34;
      end
      default: begin
        if (y == '0) begin
          e.hi = x; e.lo = '1; e.dbz = 1'b1; e.lat = 1;
        end else if (o == 3'b010) begin
          e.lo = x / y; e.hi = x % y; e.lat = 33;
        end else begin
          q = sx / sy; r = sx % sy;
          e.lo = q[31:0]; e.hi = r[31:0]; e.lat = 34;
        end
      end
    endcase
    e.busy_cyc = e.lat - 1;
    return e;
  endfunction

  // Issue one mul/div, optionally pulse start with poke_op at cycle poke_at while busy.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int poke_at, input logic [2:0] poke_op);
    exp_t g;
    int n, bc;
    logic stable;
    logic [W-1:0] pre_hi, pre_lo;
    sb_q.push_back(model(tag, o, x, y));
    pre_hi = hi; pre_lo = lo;
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n = 1; bc = 0; stable = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) bc++;
      if (hi !== pre_hi || lo !== pre_lo) stable = 1'b0;
      start = (n == poke_at);
      op = poke_op;
      a = 32'h5555_AAAA;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    g = sb_q.pop_front();
    check({g.tag, "_latency"}, 64'(n), 64'(g.lat));
    check({g.tag, "_hi"}, 64'(hi), 64'(g.hi));
    check({g.tag, "_lo"}, 64'(lo), 64'(g.lo));
    check({g.tag, "_dbz"}, 64'(div_by_zero), 64'(g.dbz));
    check({g.tag, "_busy_cycles"}, 64'(bc), 64'(g.busy_cyc));
    check({g.tag, "_busy_at_done"}, 64'(busy), 64'(0));
    check({g.tag, "_hilo_stable"}, 64'(stable), 64'(1));
    @(posedge clk); #1;
    check({g.tag, "_done_pulse"}, 64'(done), 64'(0));
    check({g.tag, "_dbz_clear"}, 64'(div_by_zero), 64'(0));
    check({g.tag, "_hi_held"}, 64'(hi), 64'(g.hi));
  endtask

  initial begin
    logic [W-1:0] ra, rb, keep_hi, keep_lo;
    logic [2:0]   rop;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dbz", 64'(div_by_zero), 64'(0));
    reset = 1'b0;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'b000);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, -1, 3'b000);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, -1, 3'b000);
    run_op("div_neg", OP_DIV, 32'hFFFF_FF9C, 32'd7, -1, 3'b000);
    run_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, -1, 3'b000);
    run_op("div_zero", OP_DIV, 32'h8000_0000, 32'd0, -1, 3'b000);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'b000);
    run_op("div_rsign", OP_DIV, 32'd7, 32'hFFFF_FFFE, -1, 3'b000);
    run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, -1, 3'b000);

    // Reset abandons an in-flight multiply and clears HI/LO.
    op = OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_hi", 64'(hi), 64'(0));
    check("abort_lo", 64'(lo), 64'(0));
    run_op("after_reset", OP_MULTU, 32'd5, 32'd6, -1, 3'b000);

    // Back-to-back MTHI/MTLO
    op = OP_MTHI; a = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
    check("mthi_busy", 64'(busy), 64'(0));
    check("mthi_done", 64'(done), 64'(0));
    op = OP_MTLO; a = 32'h0BAD_F00D;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h0BAD_F00D);
    check("mtlo_hi", 64'(hi), 64'hDEAD_BEEF);
    check("mtlo_busy", 64'(busy), 64'(0));

    // Starts while busy must be ignored.
    run_op("poke_mtlo", OP_MULTU, 32'd3, 32'd4, 5, OP_MTLO);
    run_op("poke_div", OP_DIVU, 32'd1000, 32'd10, 7, OP_MULTU);

    // Reserved codes are NOPs.
    keep_hi = hi; keep_lo = lo;
    op = 3'b110; a = 32'hFFFF_0000; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    op = 3'b111;
    check("rsv6_busy", 64'(busy), 64'(0));
    check("rsv6_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    check("rsv7_busy", 64'(busy), 64'(0));
    check("rsv7_done", 64'(done), 64'(0));
    check("rsv_hi", 64'(hi), 64'(keep_hi));
    check("rsv_lo", 64'(lo), 64'(keep_lo));

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 4) ? 32'd0 : $urandom;
      run_op($sformatf("rand%0d", i), rop, ra, rb, -1, 3'b000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
